// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the multi-requester FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST      = 4;

  // Candidate index visited at a given step of the round-robin search.
  function automatic int rr_index(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO-side signal bundle of the write arbiter.
interface fifo_wr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic                          full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [$clog2(NUM_REQ)-1:0]    owner;
  logic                          busy;

  modport slave (
    input  req, wdata, full,
    output gnt, w_en, data_in, owner, busy
  );

  modport master (
    output req, wdata, full,
    input  gnt, w_en, data_in, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: first active requester after last_i, wrapping, last_i itself last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic                       found_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int OW = $clog2(NUM_REQ);

  logic          found_s;
  logic [OW-1:0] idx_s;
  int            cand_s;

  // Walk the candidates in priority order and keep the first hit.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {OW{1'b0}};
    cand_s  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = rr_index(int'(last_i), k, NUM_REQ);
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        idx_s   = OW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign found_o = found_s;
  assign idx_o   = idx_s;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting NUM_REQ writers bounded bursts into one FIFO write port.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST      = DEF_BURST
) (
  input  logic          wclk,
  input  logic          wrst_n,
  fifo_wr_arb_if.slave  bus
);

  localparam int            OW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic          idle_found_s, next_found_s;
  logic [OW-1:0] idle_idx_s, next_idx_s;
  logic          busy_s, owner_req_s, xfer_s, tenure_end_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_idle (
    .req_i   (bus.req),
    .last_i  (last_owner_q),
    .found_o (idle_found_s),
    .idx_o   (idle_idx_s)
  );

  // At tenure end the search starts after the owner that is just leaving.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_next (
    .req_i   (bus.req),
    .last_i  (owner_q),
    .found_o (next_found_s),
    .idx_o   (next_idx_s)
  );

  // Transfer qualification and tenure termination.
  always_comb begin
    busy_s       = (state_q == BUSY);
    owner_req_s  = bus.req[owner_q];
    xfer_s       = busy_s && !bus.full && owner_req_s;
    tenure_end_s = busy_s && ((xfer_s && (burst_cnt_q == CNT_LAST)) || !owner_req_s);
  end

  // Grant is withheld entirely while the FIFO is full.
  always_comb begin
    bus.gnt = {NUM_REQ{1'b0}};
    if (busy_s && !bus.full) begin
      bus.gnt[owner_q] = 1'b1;
    end else begin
      bus.gnt = {NUM_REQ{1'b0}};
    end
  end

  assign bus.w_en    = xfer_s;
  assign bus.data_in = bus.wdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_s;

  // Next-state: arbitration from IDLE, burst counting and zero-gap handover in BUSY.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_found_s) begin
          state_d     = BUSY;
          owner_d     = idle_idx_s;
          burst_cnt_d = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (tenure_end_s) begin
          last_owner_d = owner_q;
          burst_cnt_d  = {CW{1'b0}};
          if (next_found_s) begin
            state_d = BUSY;
            owner_d = next_idx_s;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer_s) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      owner_q      <= {OW{1'b0}};
      last_owner_q <= OW'(NUM_REQ - 1);
      burst_cnt_q  <= {CW{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: expected FIFO words queued per scenario, popped on each w_en.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic wclk = 1'b0;
  logic wrst_n;

  fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST(BL)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(8'hA0 + i);
  endfunction

  // Every FIFO write is matched against the next expected word and must be a legal grant.
  always @(negedge wclk) begin
    if (mon_en && bus.w_en === 1'b1) begin
      logic [DW-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra_write: data_in=%h written, no write expected", bus.data_in);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_in !== e) $display("FAIL sb_word: data_in=%h expected %h", bus.data_in, e);
        else n_pass++;
      end
      n_checks++;
      if (bus.req[bus.owner] !== 1'b1 || bus.gnt[bus.owner] !== 1'b1)
        $display("FAIL write_legal: owner=%0d req=%b gnt=%b, need req&gnt at owner", bus.owner, bus.req, bus.gnt);
      else n_pass++;
    end
  end

  task automatic apply_reset();
    wrst_n   = 1'b0;
    bus.req  = 4'b0000;
    bus.full = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.w_en !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_ctrl: gnt=%b w_en=%b busy=%b expected 0/0/0", bus.gnt, bus.w_en, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.owner !== 2'd0 || bus.data_in !== word_of(0))
      $display("FAIL reset_data: owner=%0d data_in=%h expected 0/%h", bus.owner, bus.data_in, word_of(0));
    else n_pass++;
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.w_en !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL idle_quiet: cycle %0d gnt=%b w_en=%b busy=%b expected 0/0/0", c, bus.gnt, bus.w_en, bus.busy);
      else n_pass++;
    end
  endtask

  task automatic test_all_req();
    apply_reset();
    for (int t = 0; t < 5; t++)
      for (int w = 0; w < BL; w++) exp_q.push_back(word_of(t % NR));
    @(posedge wclk); #1;
    bus.req = 4'b1111;
    @(negedge wclk);
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
      $display("FAIL arb_cycle: gnt=%b busy=%b expected 0000/0", bus.gnt, bus.busy);
    else n_pass++;
    @(posedge wclk);
    for (int c = 0; c < 20; c++) begin
      @(negedge wclk);
      n_checks++;
      if (bus.w_en !== 1'b1) $display("FAIL all_req_gap: cycle %0d w_en=%b expected 1", c, bus.w_en);
      else n_pass++;
    end
    @(posedge wclk); #1;
    bus.req = 4'b0000;
    repeat (3) @(posedge wclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL all_req_drain: left=%0d busy=%b expected 0/0", exp_q.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_single_owner();
    apply_reset();
    for (int w = 0; w < 12; w++) exp_q.push_back(word_of(2));
    @(posedge wclk); #1;
    bus.req = 4'b0100;
    @(posedge wclk);
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      n_checks++;
      if (bus.w_en !== 1'b1 || bus.owner !== 2'd2)
        $display("FAIL single_stream: cycle %0d w_en=%b owner=%0d expected 1/2", c, bus.w_en, bus.owner);
      else n_pass++;
    end
    @(posedge wclk); #1;
    bus.req = 4'b0000;
    repeat (3) @(posedge wclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL single_drain: left=%0d busy=%b expected 0/0", exp_q.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    logic [9:0] exp_wen;
    exp_wen = 10'b11111_00011;
    apply_reset();
    for (int w = 0; w < 4; w++) exp_q.push_back(word_of(0));
    for (int w = 0; w < 3; w++) exp_q.push_back(word_of(1));
    @(posedge wclk); #1;
    bus.req = 4'b0011;
    @(posedge wclk);
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      n_checks++;
      if (bus.w_en !== exp_wen[c]) $display("FAIL full_wen: cycle %0d w_en=%b expected %b", c, bus.w_en, exp_wen[c]);
      else n_pass++;
      if (bus.full) begin
        n_checks++;
        if (bus.gnt !== 4'b0000) $display("FAIL full_gnt: cycle %0d gnt=%b expected 0000", c, bus.gnt);
        else n_pass++;
      end
      @(posedge wclk); #1;
      bus.full = (c + 1 >= 2 && c + 1 <= 4);
    end
    bus.req = 4'b0000;
    repeat (3) @(posedge wclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL full_drain: left=%0d busy=%b expected 0/0", exp_q.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_req_drop();
    apply_reset();
    exp_q.push_back(word_of(1));
    exp_q.push_back(word_of(3));
    @(posedge wclk); #1;
    bus.req = 4'b1010;
    @(posedge wclk);
    @(negedge wclk);
    @(posedge wclk); #1;
    bus.req = 4'b1000;
    @(negedge wclk);
    n_checks++;
    if (bus.w_en !== 1'b0) $display("FAIL drop_no_write: w_en=%b expected 0", bus.w_en);
    else n_pass++;
    @(posedge wclk); #1;
    n_checks++;
    if (bus.owner !== 2'd3 || bus.busy !== 1'b1)
      $display("FAIL drop_handover: owner=%0d busy=%b expected 3/1", bus.owner, bus.busy);
    else n_pass++;
    @(negedge wclk);
    @(posedge wclk); #1;
    bus.req = 4'b0000;
    repeat (3) @(posedge wclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL drop_drain: left=%0d busy=%b expected 0/0", exp_q.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    exp_q.push_back(word_of(2));
    exp_q.push_back(word_of(2));
    exp_q.push_back(word_of(1));
    @(posedge wclk); #1;
    bus.req = 4'b0100;
    @(posedge wclk);
    @(negedge wclk);
    @(negedge wclk);
    @(posedge wclk); #1;
    bus.req = 4'b0110;
    wrst_n  = 1'b0;
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.w_en !== 1'b0 || bus.busy !== 1'b0 ||
        bus.owner !== 2'd0 || bus.data_in !== word_of(0))
      $display("FAIL midrst_outputs: gnt=%b w_en=%b busy=%b owner=%0d data_in=%h expected 0000/0/0/0/%h",
               bus.gnt, bus.w_en, bus.busy, bus.owner, bus.data_in, word_of(0));
    else n_pass++;
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    n_checks++;
    if (bus.owner !== 2'd1 || bus.busy !== 1'b1 || bus.gnt !== 4'b0010)
      $display("FAIL midrst_first_owner: owner=%0d busy=%b gnt=%b expected 1/1/0010", bus.owner, bus.busy, bus.gnt);
    else n_pass++;
    @(negedge wclk);
    @(posedge wclk); #1;
    bus.req = 4'b0000;
    repeat (3) @(posedge wclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL midrst_drain: left=%0d busy=%b expected 0/0", exp_q.size(), bus.busy);
    else n_pass++;
  endtask

  initial begin
    wrst_n   = 1'b0;
    bus.req  = 4'b0000;
    bus.full = 1'b0;
    for (int i = 0; i < NR; i++) bus.wdata[i*DW +: DW] = word_of(i);
    mon_en = 1'b1;
    test_reset();
    test_all_req();
    test_single_owner();
    test_full_stall();
    test_req_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, FIFO word width.
REQ-003 Parameter BURST, default 4, max words per grant tenure (1..16).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-006 wrst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  per-requester write request; bit i = requester i.
REQ-008 wdata  input  NUM_REQ*DATA_WIDTH  requester i word in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 gnt  output  NUM_REQ  one-hot-or-zero grant; a word is accepted when req[i] & gnt[i] is high at a wclk edge.
REQ-010 full  input  1  FIFO full flag, same wclk domain.
REQ-011 w_en  output  1  FIFO write enable.
REQ-012 data_in  output  DATA_WIDTH  FIFO write data.
REQ-013 owner  output  clog2(NUM_REQ)  index of current owner; valid only while busy=1.
REQ-014 busy  output  1  high in state BUSY.

Function
REQ-015 FSM states SHALL be IDLE and BUSY only.
REQ-016 Registered state: state, owner, last_owner, burst_cnt (clog2(BURST)+1 bits).
REQ-017 gnt SHALL be combinational: onehot(owner) when state==BUSY and full==0, else all-zero.
REQ-018 Transfer SHALL be defined as state==BUSY & !full & req[owner].
REQ-019 w_en SHALL equal transfer combinationally; data_in SHALL equal wdata slice [owner] (zero-latency path, no write issued while full).
REQ-020 Round-robin pick: first requester with req high, searching last_owner+1, last_owner+2, ... with modulo-NUM_REQ wrap, last_owner included last.
REQ-021 IDLE: if any req high, go to BUSY next cycle with owner=pick, burst_cnt=0; else stay IDLE. No grant is issued in the arbitration cycle.
REQ-022 BUSY, on transfer: burst_cnt increments.
REQ-023 Tenure SHALL end when a transfer occurs with burst_cnt==BURST-1, or when req[owner]==0.
REQ-024 At tenure end, last_owner SHALL be set to owner.
REQ-025 At tenure end, if pick (computed with updated last_owner) finds any req, stay BUSY with new owner and burst_cnt=0 in the same edge; else go to IDLE.
REQ-026 BUSY with full==1: gnt=0; burst_cnt and owner SHALL hold. Tenure ends only via req[owner]==0.
REQ-027 Requester dropping req mid-burst SHALL lose no accepted word; no word is accepted from it after the drop cycle.
REQ-028 BURST==1 SHALL rotate owner after every transfer.
REQ-029 A word SHALL never be written for a requester whose req is low.

Reset
REQ-030 On wrst_n low, asynchronously: state=IDLE, owner=0, last_owner=NUM_REQ-1, burst_cnt=0.
REQ-031 During reset, outputs SHALL be gnt=0, w_en=0, busy=0, owner=0, data_in=wdata slice 0.
REQ-032 Reset asserted mid-burst SHALL abort the tenure; the first grant after release goes to the lowest-index active requester.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the state typedef (IDLE, BUSY) and default NUM_REQ/BURST constants.
REQ-034 Sub-module rr_pick (combinational: req vector + last_owner -> found flag + index) SHALL implement REQ-020.

Verification
REQ-035 Reset release with req=4'b0000 -> gnt=0, w_en=0, busy=0 for 10 cycles.
REQ-036 req=4'b1111 held, full=0, BURST=4 -> words written in order: 4 from req0, 4 from req1, 4 from req2, 4 from req3, then 4 from req0 again. Each tenure change takes no idle cycle.
REQ-037 Only req2 held, BURST=4 -> after 1 arbitration cycle, w_en continuously high. owner rolls 2->2 every 4 words with no gap.
REQ-038 req0 bursting, full=1 for 3 cycles after 2nd word -> gnt=0 and w_en=0 for those 3 cycles. Then 2 more req0 words follow before rotation.
REQ-039 req1 drops after 1 word while req3 high -> next edge owner=3. Exactly 1 word from req1 written.
REQ-040 wrst_n pulsed low mid-burst of req2 with req=4'b0110 -> outputs zero immediately. After release, first owner=1.
